dmem_access_ctrl: RTL



---
 rtl/dmem_access_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 21 ++
 rtl/dmem_access_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access sequencer.
// Holds the datapath width and the controller state encoding.
package dmem_access_ctrl_pkg;

  localparam int DATA_W = 32;

  // Encoding 2'd3 is unused and decodes as IDLE in the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Synchronous active-high reset; clr has the same effect as reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores over a req/ack handshake to variable-latency memory,
// stalling the front of the pipeline until the access completes or times out.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUresultM,
  input  logic [DATA_W-1:0] ReadData2M,
  output logic              DmemReq,
  output logic              DmemWe,
  output logic [DATA_W-1:0] DmemAddr,
  output logic [DATA_W-1:0] DmemWdata,
  input  logic              DmemAck,
  input  logic [DATA_W-1:0] DmemRdata,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              Stall,
  output logic              BubbleW,
  output logic              TimeoutErr,
  output logic [CNT_W-1:0]  StallCycles
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            op;
  logic            to_hit;

  assign op      = MemReadM | MemWriteM;
  assign to_hit  = (to_cnt == TO_LAST);
  assign BubbleW = Stall;

  always_comb begin
    state_nxt = ST_IDLE;
    Stall     = 1'b0;
    case (state)
      ST_REQ: begin
        Stall     = 1'b1;
        state_nxt = (DmemAck || to_hit) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        if (op) begin
          Stall     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      DmemReq    <= 1'b0;
      DmemWe     <= 1'b0;
      DmemAddr   <= '0;
      DmemWdata  <= '0;
      ReadDataM  <= '0;
      TimeoutErr <= 1'b0;
      to_cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_REQ: begin
          if (DmemAck) begin
            if (!DmemWe) ReadDataM <= DmemRdata;
            DmemReq <= 1'b0;
          end else if (to_hit) begin
            DmemReq    <= 1'b0;
            ReadDataM  <= '0;
            TimeoutErr <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_DONE: begin
        end
        default: begin
          // A simultaneous read+write is issued as a write.
          if (op) begin
            DmemAddr  <= ALUresultM;
            DmemWdata <= ReadData2M;
            DmemWe    <= MemWriteM;
            DmemReq   <= 1'b1;
            to_cnt    <= '0;
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .inc   (Stall),
    .clr   (1'b0),
    .count (StallCycles)
  );

endmodule
